// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] AddrCount   = 5'd9;
  localparam logic [4:0] AddrCompare = 5'd11;
  localparam logic [4:0] AddrSr      = 5'd12;
  localparam logic [4:0] AddrCause   = 5'd13;
  localparam logic [4:0] AddrEpc     = 5'd14;
  localparam logic [4:0] AddrPrid    = 5'd15;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  localparam int unsigned SrIe       = 0;
  localparam int unsigned SrExl      = 1;
  localparam int unsigned SrImLo     = 10;
  localparam int unsigned CauseExcLo = 2;
  localparam int unsigned CauseIpLo  = 10;
  localparam int unsigned CauseTi    = 30;
  localparam int unsigned CauseBd    = 31;
  localparam int unsigned IpWidth    = 6;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer; TI latches on a Count==Compare match until Compare is rewritten.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] din_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        count_we, compare_we;

  assign count_we   = we_i && (addr_i == AddrCount);
  assign compare_we = we_i && (addr_i == AddrCompare);

  always_comb begin
    count_d   = count_we ? din_i : count_q + 32'd1;
    compare_d = compare_we ? din_i : compare_q;
    // Clearing by a Compare write wins over a match in the same cycle.
    ti_d      = compare_we ? 1'b0 : (ti_q | (count_q == compare_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// CP0 exception/interrupt block: SR, Cause, EPC, PRId and optional timer.
// Define CP0_TIMER_EN to build the Count/Compare timer (cp0_timer).
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HWINT = 5,
  parameter logic [31:0] PRID_VAL  = 32'h1506_1100
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [4:0]           Addr,
  input  logic [31:0]          DIn,
  input  logic                 We,
  input  logic [31:0]          PC,
  input  logic                 BD,
  input  logic                 ExcReq,
  input  logic [4:0]           ExcCode,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic                 IntReq,
  output logic                 ExcEntry,
  output logic [31:0]          EPC,
  output logic [31:0]          DOut
);

  logic [IpWidth-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        prid_q, prid_d;

  logic [31:0]        count, compare;
  logic               ti;
  logic [IpWidth-1:0] ip;
  logic               sr_we, epc_we, prid_we;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .we_i      (We),
    .addr_i    (Addr),
    .din_i     (DIn),
    .count_o   (count),
    .compare_o (compare),
    .ti_o      (ti)
  );
`else
  assign count   = 32'd0;
  assign compare = 32'd0;
  assign ti      = 1'b0;
`endif

  // Unused HWInt slots zero-extend into IP[14:10]; IP[15] is the timer.
  assign ip = {ti, 5'(HWInt)};

  assign sr_we   = We && (Addr == AddrSr);
  assign epc_we  = We && (Addr == AddrEpc);
  assign prid_we = We && (Addr == AddrPrid);

  assign IntReq   = (|(ip & im_q)) & ie_q & ~exl_q;
  assign ExcEntry = IntReq | (ExcReq & ~exl_q);
  assign EPC      = epc_we ? DIn : epc_q;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    prid_d     = prid_q;
    if (ExcEntry) begin
      exl_d      = 1'b1;
      bd_d       = BD;
      epc_d      = BD ? PC - 32'd4 : PC;
      exc_code_d = IntReq ? ExcInt : ExcCode;
    end else begin
      if (EXLClr) begin
        exl_d = 1'b0;
      end else if (sr_we) begin
        im_d  = DIn[SrImLo +: IpWidth];
        exl_d = DIn[SrExl];
        ie_d  = DIn[SrIe];
      end
      if (epc_we) begin
        epc_d = DIn;
      end
    end
    if (prid_we) begin
      prid_d = DIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      prid_q     <= PRID_VAL;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      prid_q     <= prid_d;
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (Addr)
      AddrCount:   DOut = count;
      AddrCompare: DOut = compare;
      AddrSr:      DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
      AddrCause:   DOut = {bd_q, ti, 14'd0, ip, 3'd0, exc_code_q, 2'd0};
      AddrEpc:     DOut = epc_q;
      AddrPrid:    DOut = prid_q;
      default:     DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
// Self-checking bench for cp0_ext: directed scenarios plus random traffic vs a register-level model.
module tb_cp0_ext;

  localparam logic [31:0] Prid = 32'h1506_1100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [4:0]  Addr = '0;
  logic [31:0] DIn = '0;
  logic        We = 1'b0;
  logic [31:0] PC = '0;
  logic        BD = 1'b0;
  logic        ExcReq = 1'b0;
  logic [4:0]  ExcCode = '0;
  logic [4:0]  HWInt = '0;
  logic        EXLClr = 1'b0;
  logic        IntReq, ExcEntry;
  logic [31:0] EPC, DOut;

  cp0_ext #(
    .NUM_HWINT (5),
    .PRID_VAL  (Prid)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Addr     (Addr),
    .DIn      (DIn),
    .We       (We),
    .PC       (PC),
    .BD       (BD),
    .ExcReq   (ExcReq),
    .ExcCode  (ExcCode),
    .HWInt    (HWInt),
    .EXLClr   (EXLClr),
    .IntReq   (IntReq),
    .ExcEntry (ExcEntry),
    .EPC      (EPC),
    .DOut     (DOut)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural state of the model, kept as plain register fields.
  int unsigned m_im, m_code;
  bit          m_exl, m_ie, m_bd, m_ti;
  logic [31:0] m_epc, m_prid, m_count, m_compare;

  logic        obs_int, obs_entry;
  logic [31:0] obs_epc, obs_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit m_intreq(input logic [4:0] hw);
    int unsigned pending;
    pending = int'(hw) + (m_ti ? 32 : 0);
    return ((pending & m_im) != 0) && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [4:0] hw);
    int unsigned pending;
    pending = int'(hw) + (m_ti ? 32 : 0);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_im * 1024 + (m_exl ? 2 : 0) + (m_ie ? 1 : 0);
      5'd13: return (m_bd ? 32'h8000_0000 : 0) + (m_ti ? 32'h4000_0000 : 0)
                    + pending * 1024 + m_code * 4;
      5'd14: return m_epc;
      5'd15: return m_prid;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = 0; m_ti = 0;
    m_epc = 0; m_prid = Prid; m_count = 0;
`ifdef CP0_TIMER_EN
    m_compare = 32'hFFFF_FFFF;
`else
    m_compare = 0;
`endif
  endtask

  task automatic m_step(input bit rst, input bit we, input logic [4:0] addr,
                        input logic [31:0] din, input logic [31:0] pc, input bit bd,
                        input bit excreq, input logic [4:0] code, input logic [4:0] hw,
                        input bit exlclr);
    bit taken_int, entry;
    if (rst) begin
      m_reset();
      return;
    end
    taken_int = m_intreq(hw);
    entry = taken_int || (excreq && !m_exl);
`ifdef CP0_TIMER_EN
    if (we && addr == 11) m_ti = 0;
    else if (m_count == m_compare) m_ti = 1;
    if (we && addr == 11) m_compare = din;
    m_count = (we && addr == 9) ? din : m_count + 1;
`endif
    if (entry) begin
      m_exl  = 1;
      m_bd   = bd;
      m_epc  = bd ? pc - 4 : pc;
      m_code = taken_int ? 0 : int'(code);
    end else begin
      if (exlclr) m_exl = 0;
      else if (we && addr == 12) begin
        m_im = (din / 1024) % 64; m_exl = din[1]; m_ie = din[0];
      end
      if (we && addr == 14) m_epc = din;
    end
    if (we && addr == 15) m_prid = din;
  endtask

  // Apply one cycle of inputs, compare combinational outputs, then clock it.
  task automatic drive(input bit rst, input bit we, input logic [4:0] addr,
                       input logic [31:0] din, input logic [31:0] pc, input bit bd,
                       input bit excreq, input logic [4:0] code, input logic [4:0] hw,
                       input bit exlclr);
    bit ei;
    Reset = rst; We = we; Addr = addr; DIn = din; PC = pc; BD = bd;
    ExcReq = excreq; ExcCode = code; HWInt = hw; EXLClr = exlclr;
    #1;
    obs_int = IntReq; obs_entry = ExcEntry; obs_epc = EPC; obs_dout = DOut;
    ei = m_intreq(hw);
    check("intreq", 32'(obs_int), 32'(ei));
    check("excentry", 32'(obs_entry), 32'(ei || (excreq && !m_exl)));
    check("epc_out", obs_epc, (we && addr == 14) ? din : m_epc);
    check("dout", obs_dout, m_read(addr, hw));
    @(posedge Clk);
    m_step(rst, we, addr, din, pc, bd, excreq, code, hw, exlclr);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd0, 0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] din);
    drive(0, 1, addr, din, 32'd0, 0, 0, 5'd0, 5'd0, 0);
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    We = 1'b0; Addr = addr;
    #1;
    check(tag, DOut, exp);
  endtask

  initial begin
    logic [4:0] addr_tbl [7];
    addr_tbl = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

    Reset = 1'b1;
    @(posedge Clk);
    #1;
    m_reset();
    Reset = 1'b0;
    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    peek("rst_prid", 5'd15, Prid);

    // Hardware interrupt entry.
    wr(5'd12, 32'h0000_0401);
    drive(0, 0, 5'd0, 32'd0, 32'h1000, 0, 0, 5'd0, 5'd1, 0);
    check("int_same_cycle", 32'(obs_int), 32'd1);
    peek("int_sr", 5'd12, 32'h0000_0403);
    peek("int_epc", 5'd14, 32'h0000_1000);
    peek("int_cause", 5'd13, 32'h0000_0400);

    // Synchronous exception in a delay slot, then a masked repeat.
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd0, 1);
    peek("eret_sr", 5'd12, 32'h0000_0401);
    drive(0, 0, 5'd0, 32'd0, 32'h3008, 1, 1, 5'd12, 5'd0, 0);
    peek("exc_epc", 5'd14, 32'h0000_3004);
    peek("exc_cause", 5'd13, 32'h8000_0030);
    peek("exc_sr", 5'd12, 32'h0000_0403);
    drive(0, 0, 5'd0, 32'd0, 32'h5000, 0, 1, 5'd4, 5'd0, 0);
    check("nested_entry", 32'(obs_entry), 32'd0);
    peek("nested_epc", 5'd14, 32'h0000_3004);
    peek("nested_cause", 5'd13, 32'h8000_0030);

    // Interrupt beats ExcReq; entry beats EXLClr.
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd0, 1);
    drive(0, 0, 5'd0, 32'd0, 32'h6000, 0, 1, 5'd12, 5'd1, 1);
    check("prio_entry", 32'(obs_entry), 32'd1);
    peek("prio_sr", 5'd12, 32'h0000_0403);
    peek("prio_cause", 5'd13, 32'h0000_0400);
    peek("prio_epc", 5'd14, 32'h0000_6000);

    // EPC write bypass versus registered read.
    wr(5'd14, 32'h0000_4180);
    check("epc_bypass", obs_epc, 32'h0000_4180);
    check("epc_old_read", obs_dout, 32'h0000_6000);
    peek("epc_new_read", 5'd14, 32'h0000_4180);

    wr(5'd13, 32'hFFFF_FFFF);
    peek("cause_ro", 5'd13, 32'd0);
    wr(5'd15, 32'hDEAD_BEEF);
    peek("prid_wr", 5'd15, 32'hDEAD_BEEF);

`ifdef CP0_TIMER_EN
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd5);
    peek("cnt_load", 5'd9, 32'd5);
    wr(5'd12, 32'h0000_8001);
    repeat (4) idle();
    peek("ti_early", 5'd13, 32'd0);
    peek("cnt_at_cmp", 5'd9, 32'd10);
    idle();
    peek("ti_set", 5'd13, 32'h4000_8000);
    idle();
    check("timer_int", 32'(obs_int), 32'd1);
    wr(5'd11, 32'h100);
    peek("ti_clear", 5'd13, 32'd0);
    wr(5'd9, 32'hFFFF_FFFF);
    peek("cnt_max", 5'd9, 32'hFFFF_FFFF);
    idle();
    peek("cnt_wrap", 5'd9, 32'd0);
`else
    wr(5'd9, 32'd5);
    wr(5'd11, 32'd7);
    peek("no_count", 5'd9, 32'd0);
    peek("no_compare", 5'd11, 32'd0);
`endif

    for (int n = 0; n < 800; n++) begin
      bit          r_rst, r_we, r_bd, r_exc, r_clr;
      logic [4:0]  r_addr, r_code, r_hw;
      logic [31:0] r_din, r_pc;
      r_rst  = ($urandom_range(0, 63) == 0);
      r_we   = ($urandom_range(0, 2) == 0);
      r_addr = addr_tbl[$urandom_range(0, 6)];
      r_din  = $urandom;
      r_pc   = $urandom & 32'hFFFF_FFFC;
      r_bd   = $urandom_range(0, 1) == 1;
      r_exc  = ($urandom_range(0, 5) == 0);
      r_code = 5'($urandom);
      r_hw   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      r_clr  = ($urandom_range(0, 7) == 0);
      if (r_clr && r_we && r_addr == 5'd12) r_clr = 0;
      drive(r_rst, r_we, r_addr, r_din, r_pc, r_bd, r_exc, r_code, r_hw, r_clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
